// File: rtl/mux_4bit.sv
`default_nettype none
// ============================================================================
// Module   : mux_4bit
// Purpose  : WIDTH-bit 2:1 word multiplexer. This is the result selector in
//            the carry-select adder. The carry out of the lower block drives
//            s and picks between the two precomputed sums.
//            The combinational output c has zero latency. A registered copy
//            c_q is also provided, with a sticky valid flag, for pipelined
//            consumers.
// Ports    : clk     in   1      rising-edge clock (registered path only)
//            rst_n   in   1      asynchronous active-low reset
//            a       in   WIDTH  operand chosen when s=0 (sum, carry-in 0)
//            b       in   WIDTH  operand chosen when s=1 (sum, carry-in 1)
//            s       in   1      select: 0 -> a, 1 -> b
//            en      in   1      capture enable for the registered path
//            c       out  WIDTH  combinational result
//            c_q     out  WIDTH  registered result
//            q_valid out  1      c_q holds a captured value
// Revision : 1.0  initial release
// ============================================================================
module mux_4bit #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             q_valid
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_c_q;
  logic             r_q_valid;

  // A plain conditional select: every bit comes from the same operand.
  // An X or Z on s follows normal ?: merge semantics, so no extra
  // X-resolution logic is added here.
  assign w_sel = s ? b : a;
  assign c     = w_sel;

  // Registered copy. The reset is asynchronous and takes priority over en.
  // Once q_valid is set it stays set until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_q     <= RST_VAL;
      r_q_valid <= 1'b0;
    end else if (en) begin
      r_c_q     <= w_sel;
      r_q_valid <= 1'b1;
    end
  end

  assign c_q     = r_c_q;
  assign q_valid = r_q_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4bit
// Purpose  : Directed self-checking bench for mux_4bit. It covers:
//            - the combinational select
//            - asynchronous reset
//            - capture and hold of the registered path
//            - the sticky valid flag
//            - an exhaustive sweep of a, b and s
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_4bit;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             en;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             q_valid;

  int checks;
  int errors;

  mux_4bit #(
    .WIDTH  (WIDTH),
    .RST_VAL(4'b0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .s      (s),
    .en     (en),
    .c      (c),
    .c_q    (c_q),
    .q_valid(q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [8:0]       v;
    logic [WIDTH-1:0] exp_c;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    a      = '0;
    b      = '0;
    s      = 1'b0;

    // Reset state
    #3;
    check("reset_c_q", {4'h0, c_q}, 8'h00);
    check("reset_q_valid", {7'h0, q_valid}, 8'h00);
    check("reset_c", {4'h0, c}, 8'h00);

    // Combinational select, with no clock edge needed
    a = 4'b1010; b = 4'b0101; s = 1'b0; #1;
    check("t1_c_s0", {4'h0, c}, 8'h0A);
    s = 1'b1; #1;
    check("t2_c_s1", {4'h0, c}, 8'h05);
    a = 4'b1000; b = 4'b0010; s = 1'b0; #1;
    check("t3_c_s0", {4'h0, c}, 8'h08);
    s = 1'b1; #1;
    check("t3_c_s1", {4'h0, c}, 8'h02);

    // Capture, then hold with en low
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; a = 4'hA; b = 4'h5; s = 1'b1;
    @(posedge clk); #1;
    check("t5_c_q_cap", {4'h0, c_q}, 8'h05);
    check("t5_q_valid", {7'h0, q_valid}, 8'h01);
    @(negedge clk);
    en = 1'b0; s = 1'b0; #1;
    check("t5_c_hold", {4'h0, c}, 8'h0A);
    @(posedge clk); #1;
    check("t5_c_q_hold", {4'h0, c_q}, 8'h05);
    check("t5_q_valid_sticky", {7'h0, q_valid}, 8'h01);
    @(posedge clk); #1;
    check("t5_c_q_hold2", {4'h0, c_q}, 8'h05);

    // Asynchronous reset mid-operation. c keeps tracking the inputs.
    // The reset also wins over en at a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0; #1;
    check("t4_async_c_q", {4'h0, c_q}, 8'h00);
    check("t4_async_q_valid", {7'h0, q_valid}, 8'h00);
    a = 4'h3; b = 4'hC; s = 1'b1; en = 1'b1; #1;
    check("t4_c_tracks", {4'h0, c}, 8'h0C);
    @(posedge clk); #1;
    check("t4_rst_over_en_c_q", {4'h0, c_q}, 8'h00);
    check("t4_rst_over_en_valid", {7'h0, q_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep. c is checked at once; c_q is checked after the next edge.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      v = 9'(i);
      a = v[8:5]; b = v[4:1]; s = v[0]; en = 1'b1;
      exp_c = v[0] ? v[4:1] : v[8:5];
      #1;
      check("sweep_c", {4'h0, c}, {4'h0, exp_c});
      @(posedge clk); #1;
      check("sweep_c_q", {4'h0, c_q}, {4'h0, exp_c});
    end
    check("sweep_q_valid", {7'h0, q_valid}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
